// File: rtl/regfile_wport_sched_pkg.sv
// regfile_wport_sched_pkg
//   Shared constants and encodings for the GPR write-port scheduler.
//   REG_ZERO : hard-wired zero register address
//   NUM_GPR  : architectural register count (r0..r31)
//   state_t  : scheduler FSM states
//   gnt_t    : which requester owns the write port this cycle
package regfile_wport_sched_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         NUM_GPR  = 32;

  typedef enum logic {
    IDLE,
    FORCE
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_LU
  } gnt_t;

endpackage

// File: rtl/regfile_wport_sched_scoreboard.sv
// regfile_scoreboard
//   Pending-destination scoreboard for long-latency (LU) instructions.
//   Optional macro: SCHED_LU_BYPASS_EN -- source lookups ignore a busy bit
//   whose register is being written by the LU this cycle.
//   Ports:
//     clk, rst                  clock, async active-high reset
//     set_en, set_addr          mark a register busy (wins over clear)
//     clr_en, clr_addr          release a register on LU write
//     rs_addr, rt_addr          source lookups
//     dst_addr                  destination lookup (WAW, never bypassed)
//     byp_en, byp_addr          LU write in flight this cycle
//     rs_busy, rt_busy, dst_busy lookup results (r0 always reads not busy)
module regfile_scoreboard
  import regfile_wport_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_addr,
  input  logic       clr_en,
  input  logic [4:0] clr_addr,
  input  logic [4:0] rs_addr,
  input  logic [4:0] rt_addr,
  input  logic [4:0] dst_addr,
  input  logic       byp_en,
  input  logic [4:0] byp_addr,
  output logic       rs_busy,
  output logic       rt_busy,
  output logic       dst_busy
);

  logic [NUM_GPR-1:1] busy;
  logic [NUM_GPR-1:0] busy_vec;

  // bit 0 pinned low so lookups of r0 never report a hazard
  assign busy_vec = {busy, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < NUM_GPR; i++) begin
        if (set_en && set_addr == 5'(i))
          busy[i] <= 1'b1;
        else if (clr_en && clr_addr == 5'(i))
          busy[i] <= 1'b0;
      end
    end
  end

`ifdef SCHED_LU_BYPASS_EN
  // register file forwards a same-cycle write, so the reader sees fresh data
  assign rs_busy = busy_vec[rs_addr] && !(byp_en && byp_addr == rs_addr);
  assign rt_busy = busy_vec[rt_addr] && !(byp_en && byp_addr == rt_addr);
`else
  logic byp_unused;
  assign byp_unused = byp_en ^ (^byp_addr);
  assign rs_busy    = busy_vec[rs_addr];
  assign rt_busy    = busy_vec[rt_addr];
`endif

  // WAW uses the pre-clear bit even when bypassing sources
  assign dst_busy = busy_vec[dst_addr];

endmodule

// File: rtl/regfile_wport_sched.sv
// regfile_wport_sched
//   Arbitrates the single GPR write port between WB (fixed priority) and the
//   long-latency unit, forcing an LU slot after MAX_WAIT lost cycles, and
//   generates the ID hazard stall from the LU destination scoreboard.
//   Optional macro: SCHED_LU_BYPASS_EN (see regfile_scoreboard).
//   Ports:
//     clk, rst                          clock, async active-high reset
//     wb_valid/wb_addr/wb_data, wb_hold WB requester and its freeze
//     lu_valid/lu_addr/lu_data, lu_ready LU requester and its accept
//     id_valid/id_rs/id_rt/id_dst/id_long, id_stall  ID stage hazard check
//     rf_we/rf_waddr/rf_wdata           register file write port
//
//   state | meaning
//   IDLE  | WB has priority, LU loss streak counted in wait_cnt
//   FORCE | LU owns the port for one cycle, WB held if it also wants it
module regfile_wport_sched
  import regfile_wport_sched_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_hold,
  input  logic        lu_valid,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_dst,
  input  logic        id_long,
  output logic        id_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  gnt_t               gnt;
  logic               rs_busy, rt_busy, dst_busy;
  logic               set_en, clr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      if (wb_valid && lu_valid) begin
        if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
          state    <= FORCE;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
      end else begin
        wait_cnt <= '0;
      end
    end else begin
      state    <= IDLE;
      wait_cnt <= '0;
    end
  end

  always_comb begin
    gnt     = GNT_NONE;
    wb_hold = 1'b0;
    if (!rst) begin
      if (state == FORCE && lu_valid) begin
        gnt     = GNT_LU;
        wb_hold = wb_valid;
      end else if (wb_valid) begin
        gnt = GNT_WB;
      end else if (lu_valid) begin
        gnt = GNT_LU;
      end
    end
  end

  always_comb begin
    rf_waddr = REG_ZERO;
    rf_wdata = '0;
    case (gnt)
      GNT_WB: begin
        rf_waddr = wb_addr;
        rf_wdata = wb_data;
      end
      GNT_LU: begin
        rf_waddr = lu_addr;
        rf_wdata = lu_data;
      end
      default: ;
    endcase
  end

  // a write to r0 is acknowledged but never reaches the array
  assign rf_we    = (gnt != GNT_NONE) && (rf_waddr != REG_ZERO);
  assign lu_ready = (gnt == GNT_LU);

  assign id_stall = !rst && id_valid && (rs_busy || rt_busy || dst_busy);
  assign set_en   = id_valid && !id_stall && id_long && (id_dst != REG_ZERO);
  assign clr_en   = lu_ready && (lu_addr != REG_ZERO);

  regfile_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_addr (id_dst),
    .clr_en   (clr_en),
    .clr_addr (lu_addr),
    .rs_addr  (id_rs),
    .rt_addr  (id_rt),
    .dst_addr (id_dst),
    .byp_en   (lu_ready),
    .byp_addr (lu_addr),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy),
    .dst_busy (dst_busy)
  );

endmodule

// File: tb/tb_regfile_wport_sched.sv
// tb_regfile_wport_sched
//   Directed stimulus with a behavioural reference model checked every
//   negedge, plus literal expectations at the key points of each scenario.
module tb_regfile_wport_sched;

  localparam int MAX_WAIT = 4;
`ifdef SCHED_LU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        wb_hold;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_addr = '0;
  logic [31:0] lu_data = '0;
  logic        lu_ready;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic [4:0]  id_dst = '0;
  logic        id_long = 1'b0;
  logic        id_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wport_sched #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_hold(wb_hold),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_long(id_long), .id_stall(id_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // streak: consecutive cycles the LU lost to WB; forced: LU owed a slot now
  int          m_streak = 0, m_streak_n = 0;
  bit          m_forced = 0, m_forced_n = 0;
  logic [31:0] m_busy = '0, m_busy_n = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_streak <= 0;
      m_forced <= 0;
      m_busy   <= '0;
    end else begin
      m_streak <= m_streak_n;
      m_forced <= m_forced_n;
      m_busy   <= m_busy_n;
    end
  end

  always @(negedge clk) begin
    automatic bit          e_lu = 0, e_wb = 0, e_hold = 0, e_stall = 0, e_we = 0;
    automatic logic [4:0]  e_addr = '0;
    automatic logic [31:0] e_data = '0;
    automatic bit          hz_rs, hz_rt, hz_dst, contend;
    automatic logic [31:0] nb;
    if (!rst) begin
      e_lu   = lu_valid && (m_forced || !wb_valid);
      e_wb   = wb_valid && !e_lu;
      e_hold = wb_valid && e_lu;
      e_addr = e_lu ? lu_addr : (e_wb ? wb_addr : 5'd0);
      e_data = e_lu ? lu_data : (e_wb ? wb_data : 32'd0);
      e_we   = (e_lu || e_wb) && e_addr != 0;
      hz_rs  = id_rs  != 0 && m_busy[id_rs]  && !(BYP && e_lu && lu_addr == id_rs);
      hz_rt  = id_rt  != 0 && m_busy[id_rt]  && !(BYP && e_lu && lu_addr == id_rt);
      hz_dst = id_dst != 0 && m_busy[id_dst];
      e_stall = id_valid && (hz_rs || hz_rt || hz_dst);
    end
    chk("model_lu_ready", {31'd0, lu_ready}, {31'd0, e_lu});
    chk("model_wb_hold",  {31'd0, wb_hold},  {31'd0, e_hold});
    chk("model_rf_we",    {31'd0, rf_we},    {31'd0, e_we});
    chk("model_rf_waddr", {27'd0, rf_waddr}, {27'd0, e_addr});
    chk("model_rf_wdata", rf_wdata, e_data);
    chk("model_id_stall", {31'd0, id_stall}, {31'd0, e_stall});
    contend    = !rst && wb_valid && lu_valid && !m_forced;
    m_forced_n <= contend && (m_streak == MAX_WAIT - 1);
    m_streak_n <= (contend && m_streak < MAX_WAIT - 1) ? m_streak + 1 : 0;
    nb = m_busy;
    if (e_lu && lu_addr != 0) nb[lu_addr] = 1'b0;
    if (id_valid && !e_stall && id_long && id_dst != 0 && !rst) nb[id_dst] = 1'b1;
    m_busy_n <= nb;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0; id_long = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // outputs held low during reset even with requests present
    #2;
    wb_valid = 1; wb_addr = 3; lu_valid = 1; lu_addr = 4; id_valid = 1;
    #1;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
    chk("rst_wb_hold", {31'd0, wb_hold}, 32'd0);
    chk("rst_id_stall", {31'd0, id_stall}, 32'd0);
    tick(); tick();
    rst = 0;
    idle_inputs();
    tick();

    // WB only
    wb_valid = 1; wb_addr = 3; wb_data = 32'hDEADBEEF;
    #1;
    chk("wb_we", {31'd0, rf_we}, 32'd1);
    chk("wb_waddr", {27'd0, rf_waddr}, 32'd3);
    chk("wb_wdata", rf_wdata, 32'hDEADBEEF);
    tick();
    wb_addr = 0;
    #1;
    chk("wb_r0_we", {31'd0, rf_we}, 32'd0);
    tick();

    // contention: WB wins cycles 0..3, cycle 4 forced to LU, cycle 5 WB
    wb_valid = 1; wb_addr = 4; wb_data = 32'h11;
    lu_valid = 1; lu_addr = 6; lu_data = 32'h66;
    for (int c = 0; c < MAX_WAIT; c++) begin
      #1;
      chk("cont_wb_waddr", {27'd0, rf_waddr}, 32'd4);
      chk("cont_lu_ready", {31'd0, lu_ready}, 32'd0);
      tick();
    end
    #1;
    chk("force_lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("force_wb_hold", {31'd0, wb_hold}, 32'd1);
    chk("force_waddr", {27'd0, rf_waddr}, 32'd6);
    chk("force_wdata", rf_wdata, 32'h66);
    tick();
    lu_addr = 10; lu_data = 32'hAA;
    #1;
    chk("post_force_waddr", {27'd0, rf_waddr}, 32'd4);
    chk("post_force_lu_ready", {31'd0, lu_ready}, 32'd0);
    tick();
    wb_valid = 0;
    #1;
    chk("lu_alone_ready", {31'd0, lu_ready}, 32'd1);
    tick();
    idle_inputs();
    tick();

    // RAW hazard on r7 released by the LU write
    id_valid = 1; id_long = 1; id_dst = 7; id_rs = 1; id_rt = 2;
    #1;
    chk("issue_long_stall", {31'd0, id_stall}, 32'd0);
    tick();
    id_long = 0; id_dst = 8; id_rs = 7; id_rt = 0;
    #1;
    chk("raw_stall", {31'd0, id_stall}, 32'd1);
    tick();
    #1;
    chk("raw_stall_hold", {31'd0, id_stall}, 32'd1);
    tick();
    lu_valid = 1; lu_addr = 7; lu_data = 32'h77;
    #1;
    chk("raw_lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("raw_stall_on_write", {31'd0, id_stall}, BYP ? 32'd0 : 32'd1);
    tick();
    lu_valid = 0;
    #1;
    chk("raw_released", {31'd0, id_stall}, 32'd0);
    tick();
    idle_inputs();
    tick();

    // set and clear of r9 in the same cycle: set wins
    lu_valid = 1; lu_addr = 9; lu_data = 32'h99;
    id_valid = 1; id_long = 1; id_dst = 9;
    #1;
    chk("same_cyc_stall", {31'd0, id_stall}, 32'd0);
    chk("same_cyc_lu_ready", {31'd0, lu_ready}, 32'd1);
    tick();
    lu_valid = 0; id_long = 0; id_dst = 0; id_rt = 9;
    #1;
    chk("set_wins_rt_stall", {31'd0, id_stall}, 32'd1);
    tick();
    id_rt = 0; id_dst = 9;
    #1;
    chk("waw_stall", {31'd0, id_stall}, 32'd1);
    tick();
    lu_valid = 1; lu_addr = 9;
    #1;
    chk("waw_preclear_stall", {31'd0, id_stall}, 32'd1);
    tick();
    lu_valid = 0;
    #1;
    chk("waw_released", {31'd0, id_stall}, 32'd0);
    tick();
    idle_inputs();
    tick();

    // id_dst=0 and LU write to r0
    id_valid = 1; id_long = 1; id_dst = 0;
    #1;
    chk("dst0_stall", {31'd0, id_stall}, 32'd0);
    tick();
    idle_inputs();
    lu_valid = 1; lu_addr = 0; lu_data = 32'h1234;
    #1;
    chk("lu_r0_ready", {31'd0, lu_ready}, 32'd1);
    chk("lu_r0_we", {31'd0, rf_we}, 32'd0);
    tick();
    idle_inputs();
    tick();

    // reset in the middle of FORCE with r5 pending
    id_valid = 1; id_long = 1; id_dst = 5;
    tick();
    idle_inputs();
    wb_valid = 1; wb_addr = 2; wb_data = 32'h22;
    lu_valid = 1; lu_addr = 12; lu_data = 32'hCC;
    for (int c = 0; c < MAX_WAIT; c++) tick();
    id_valid = 1; id_rs = 5;
    #1;
    chk("pre_rst_force", {31'd0, lu_ready}, 32'd1);
    chk("pre_rst_stall", {31'd0, id_stall}, 32'd1);
    rst = 1;
    #1;
    chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
    chk("mid_rst_stall", {31'd0, id_stall}, 32'd0);
    tick();
    rst = 0;
    #1;
    chk("after_rst_idle", {31'd0, lu_ready}, 32'd0);
    chk("after_rst_waddr", {27'd0, rf_waddr}, 32'd2);
    chk("after_rst_busy_clear", {31'd0, id_stall}, 32'd0);
    tick();
    idle_inputs();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
